seq_signed_divider: RTL and testbench

Iterative 32-bit signed integer divider, the inverse operation to the combinational Booth multiplier in the ALU multiplier/divider group. It accepts a dividend and divisor with a start pulse and computes the quotient and remainder radix-2, one bit per clock. It reports completion with a one-cycle done pulse. The ALU result mux consumes it alongside the multiplier product.

---
 rtl/seq_signed_divider.sv | 181 ++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// ---------------------------------------------------------------------------
// seq_signed_divider
//
// Iterative two's-complement signed divider. Operands are converted to
// magnitudes on the start edge. A restoring radix-2 loop then produces one
// quotient bit per clock for WIDTH clocks. A final FIX cycle applies the
// signs, the divide-by-zero override and the overflow override, registers
// the results and pulses done. The latency from the start edge to the done
// pulse is always WIDTH+1 edges.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        request, sampled only while idle
//   dividend     signed dividend, captured with start
//   divisor      signed divisor, captured with start
//   busy         operation in progress
//   done         one-cycle pulse, quotient/remainder/flags valid
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, sign follows the dividend
//   div_by_zero  divisor was zero (registered with done)
//   overflow     most-negative dividend divided by -1 (registered with done)
// ---------------------------------------------------------------------------
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvsrMag;
    logic [WIDTH-1:0] r_dividendRaw;
    logic [CW-1:0]    r_cnt;
    logic             r_qNeg;
    logic             r_rNeg;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_divByZero;
    logic             r_overflow;

    logic [WIDTH-1:0] w_dividendMag;
    logic [WIDTH-1:0] w_divisorMag;
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_remMag;
    logic [WIDTH-1:0] w_quoSigned;
    logic [WIDTH-1:0] w_remSigned;

    // Magnitudes of the raw operands. Negating the most negative value wraps
    // back to itself, which read as unsigned is exactly 2^(WIDTH-1).
    assign w_dividendMag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    assign w_divisorMag  = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and trial-subtract the divisor. The extra top bit of the
    // trial difference is its sign, so a clear MSB means the divisor fits.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {2'b00, r_dvsrMag};
    assign w_fits    = ~w_trial[WIDTH+1];

    // Sign correction applied in the FIX cycle.
    assign w_remMag    = r_rem[WIDTH-1:0];
    assign w_quoSigned = r_qNeg ? ('0 - r_quo) : r_quo;
    assign w_remSigned = r_rNeg ? ('0 - w_remMag) : w_remMag;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: WIDTH iteration cycles, then one fix-up cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (r_cnt == CW'(WIDTH - 1)) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath: operand capture, iteration and result registration.
    // The special-case overrides only replace values in FIX, so every
    // operand combination still spends exactly WIDTH cycles iterating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo         <= '0;
            r_rem         <= '0;
            r_dvsrMag     <= '0;
            r_dividendRaw <= '0;
            r_cnt         <= '0;
            r_qNeg        <= 1'b0;
            r_rNeg        <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovf         <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_done        <= 1'b0;
            r_divByZero   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_quo         <= w_dividendMag;
                        r_rem         <= '0;
                        r_dvsrMag     <= w_divisorMag;
                        r_dividendRaw <= dividend;
                        r_qNeg        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_rNeg        <= dividend[WIDTH-1];
                        r_dbz         <= (divisor == '0);
                        r_ovf         <= (dividend == MIN_VAL) && (divisor == '1);
                        r_cnt         <= '0;
                    end
                end
                RUN: begin
                    r_rem <= w_fits ? w_trial[WIDTH:0] : w_shifted[WIDTH:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    if (r_dbz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividendRaw;
                    end else if (r_ovf) begin
                        r_quotient  <= MIN_VAL;
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= w_quoSigned;
                        r_remainder <= w_remSigned;
                    end
                    r_divByZero <= r_dbz;
                    r_overflow  <= r_ovf & ~r_dbz;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_divByZero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_signed_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_signed_divider
//
// Directed bench for seq_signed_divider. Each issued request pushes its
// hand-computed result onto a queue; an independent monitor pops and
// compares on every done pulse, including the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_seq_signed_divider;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        logic             ovf;
        int               startEdge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleCount = 0;
    logic prevDone = 1'b0;

    seq_signed_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Free-running clock and edge counter used for latency measurement.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (!rst && done) begin
            checkOutput("donePulseWidth", {31'b0, prevDone}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, required no pending result", cycleCount);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("divByZero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                checkOutput("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                checkOutput("latency", WIDTH'(cycleCount - e.startEdge), WIDTH'(LATENCY));
                checkOutput("busyAtDone", {31'b0, busy}, 32'd0);
            end
        end
        prevDone = done;
    end

    // Drive one request in the current cycle; the next posedge samples it.
    task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                                 input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR,
                                 input logic expDbz, input logic expOvf, input bit track);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        if (track) begin
            e.q         = expQ;
            e.r         = expR;
            e.dbz       = expDbz;
            e.ovf       = expOvf;
            e.startEdge = cycleCount + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
    endtask

    // Bounded wait for a done pulse; returns on the negedge where it is seen.
    task automatic waitDone(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: got no done after %0d cycles, required done within %0d", n, budget);
        end
    endtask

    task automatic runOne(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                          input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR,
                          input logic expDbz, input logic expOvf);
        @(negedge clk);
        applyStimulus(dvd, dvs, expQ, expR, expDbz, expOvf, 1'b1);
        waitDone(LATENCY + 10);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetQuotient", quotient, 32'd0);
        checkOutput("resetRemainder", remainder, 32'd0);
        rst = 1'b0;

        // 100 / 7, also confirming busy rises right after the start edge.
        @(negedge clk);
        applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
        checkOutput("busyAfterStart", {31'b0, busy}, 32'd1);
        waitDone(LATENCY + 10);

        runOne(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runOne(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        runOne(-32'sd90, -32'sd9, 32'd10, 32'd0, 1'b0, 1'b0);
        runOne(32'd98765, 32'd0, 32'hFFFF_FFFF, 32'd98765, 1'b1, 1'b0);
        runOne(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        runOne(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0);

        // A start while busy must be ignored; a start in the done cycle is taken.
        @(negedge clk);
        applyStimulus(32'd246642, -32'sd2222, -32'sd111, 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        applyStimulus(32'd5, 32'd1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        waitDone(LATENCY + 10);
        applyStimulus(-32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 1'b0, 1'b1);
        waitDone(LATENCY + 10);

        // Reset mid-operation aborts it with no done pulse afterwards.
        @(negedge clk);
        applyStimulus(32'd801600, -32'sd200, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortQuotient", quotient, 32'd0);
        checkOutput("abortRemainder", remainder, 32'd0);
        checkOutput("abortDone", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LATENCY + 8) @(negedge clk);

        runOne(32'd0, 32'd98765, 32'd0, 32'd0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("pendingResults", WIDTH'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
